// File: rtl/pattern_player_pkg.sv
// Shared types and constants for the pattern player and its pipe-in prefetcher.
package pattern_player_pkg;

    localparam int unsigned PIPE_W        = 16;
    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned TERM_CNT      = 0;

    // Position of each word within a (pattern, hold-count) entry.
    localparam logic WORD_PAT = 1'b0;
    localparam logic WORD_CNT = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWait
    } state_e;

endpackage

// File: rtl/pattern_player_prefetch.sv
// Pipe-in FIFO reader: fetches one (pattern, count) entry ahead into a staging register.
module pattern_prefetch
    import pattern_player_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic              ep_clk,
    input  logic              ep_reset_n,
    input  logic              busy,
    input  logic              consume,
    input  logic              flush,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [PIPE_W-1:0] fifo_data,
    output logic [PIPE_W-1:0] stg_pat,
    output logic [CNT_W-1:0]  stg_cnt,
    output logic              stg_full,
    output logic              cnt_arriving
);

    logic [1:0]        rd_cnt_q;
    logic [1:0]        rd_base;
    logic              pend_q;
    logic              pend_idx_q;
    logic              term_q;
    logic              stg_full_q;
    logic [PIPE_W-1:0] stg_pat_q;
    logic [CNT_W-1:0]  stg_cnt_q;

    // A consume this cycle frees the staging slot, so the next entry's first read
    // may overlap it; that is what keeps two-cycle entries gapless.
    always_comb begin
        rd_base = consume ? 2'd0 : rd_cnt_q;
        fifo_rd = busy && !flush && !fifo_empty && !term_q &&
                  (consume || (!stg_full_q && (rd_cnt_q < 2'd2)));
    end

    always_ff @(posedge ep_clk or negedge ep_reset_n) begin
        if (!ep_reset_n) begin
            rd_cnt_q   <= 2'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= WORD_PAT;
            term_q     <= 1'b0;
            stg_full_q <= 1'b0;
            stg_pat_q  <= '0;
            stg_cnt_q  <= '0;
        end else if (flush) begin
            rd_cnt_q   <= 2'd0;
            pend_q     <= 1'b0;
            term_q     <= 1'b0;
            stg_full_q <= 1'b0;
        end else begin
            rd_cnt_q   <= rd_base + {1'b0, fifo_rd};
            pend_q     <= fifo_rd;
            pend_idx_q <= rd_base[0];
            if (pend_q && (pend_idx_q == WORD_PAT)) begin
                stg_pat_q <= fifo_data;
            end
            if (pend_q && (pend_idx_q == WORD_CNT)) begin
                // A count taken straight off the bus by the player never occupies staging.
                stg_cnt_q  <= fifo_data[CNT_W-1:0];
                stg_full_q <= !consume;
                term_q     <= (fifo_data[CNT_W-1:0] == CNT_W'(TERM_CNT));
            end else if (consume) begin
                stg_full_q <= 1'b0;
            end
        end
    end

    assign stg_pat      = stg_pat_q;
    assign stg_cnt      = stg_cnt_q;
    assign stg_full     = stg_full_q;
    assign cnt_arriving = pend_q && (pend_idx_q == WORD_CNT);

endmodule

// File: rtl/pattern_player.sv
// Replays (pattern, hold-count) entries from the pipe-in FIFO onto 16 output lines.
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter logic [PIPE_W-1:0] IDLE_PATTERN = 16'h0000,
    parameter int unsigned       CNT_W        = CNT_W_DEFAULT
) (
    input  logic              ep_clk,
    input  logic              ep_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [PIPE_W-1:0] fifo_data,
    output logic [PIPE_W-1:0] pat_out,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [15:0]       entry_cnt
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cur_cnt_q, cur_cnt_d;
    logic [PIPE_W-1:0] pat_q, pat_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       entry_cnt_q, entry_cnt_d;

    logic              consume;
    logic              flush;
    logic              load;
    logic              expire;
    logic [PIPE_W-1:0] stg_pat;
    logic [CNT_W-1:0]  stg_cnt;
    logic [CNT_W-1:0]  ld_cnt;
    logic              stg_full;
    logic              cnt_arriving;

    pattern_prefetch #(
        .CNT_W (CNT_W)
    ) u_prefetch (
        .ep_clk       (ep_clk),
        .ep_reset_n   (ep_reset_n),
        .busy         (busy),
        .consume      (consume),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .fifo_data    (fifo_data),
        .stg_pat      (stg_pat),
        .stg_cnt      (stg_cnt),
        .stg_full     (stg_full),
        .cnt_arriving (cnt_arriving)
    );

    always_comb begin
        state_d     = state_q;
        cur_cnt_d   = cur_cnt_q;
        pat_d       = pat_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        entry_cnt_d = entry_cnt_q;
        load        = 1'b0;
        ld_cnt      = stg_cnt;
        consume     = 1'b0;
        flush       = 1'b0;
        expire      = (cur_cnt_q == CNT_W'(1));

        if (abort) begin
            flush     = 1'b1;
            state_d   = StIdle;
            pat_d     = IDLE_PATTERN;
            cur_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d     = StRun;
                        underrun_d  = 1'b0;
                        entry_cnt_d = 16'd0;
                        cur_cnt_d   = '0;
                    end
                end
                StRun: begin
                    // cur_cnt == 0 means no entry has started since start.
                    if ((cur_cnt_q == '0) || expire) begin
                        if (stg_full) begin
                            load = 1'b1;
                        end else if (expire && cnt_arriving) begin
                            load   = 1'b1;
                            ld_cnt = fifo_data[CNT_W-1:0];
                        end else if (expire) begin
                            state_d    = StWait;
                            underrun_d = 1'b1;
                            cur_cnt_d  = '0;
                        end
                    end else begin
                        cur_cnt_d = cur_cnt_q - CNT_W'(1);
                    end
                end
                StWait: begin
                    if (stg_full) begin
                        load = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (load) begin
                consume = 1'b1;
                if (ld_cnt == CNT_W'(TERM_CNT)) begin
                    flush     = 1'b1;
                    state_d   = StIdle;
                    pat_d     = IDLE_PATTERN;
                    cur_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    state_d     = StRun;
                    pat_d       = stg_pat;
                    cur_cnt_d   = ld_cnt;
                    entry_cnt_d = (entry_cnt_q == 16'hFFFF) ? entry_cnt_q : entry_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge ep_clk or negedge ep_reset_n) begin
        if (!ep_reset_n) begin
            state_q     <= StIdle;
            cur_cnt_q   <= '0;
            pat_q       <= IDLE_PATTERN;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            entry_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cur_cnt_q   <= cur_cnt_d;
            pat_q       <= pat_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            entry_cnt_q <= entry_cnt_d;
        end
    end

    assign pat_out   = pat_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign underrun  = underrun_q;
    assign entry_cnt = entry_cnt_q;

endmodule
